fir_coeff_loader: RTL and testbench

- Upstream companion of the N-bit tapped-delay FIR: accepts coefficients as a serial word stream over a valid/ready handshake and assembles them in a shadow bank.
- Drives the FIR's flat coefficient bus, tap 0 in the LSBs.
- Swaps the whole bank atomically, only when the apply strobe allows it, so the filter never runs with a half-loaded coefficient set.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_coeff_loader_if.sv | 29 ++
 rtl/fir_coeff_bank.sv | 47 ++++
 rtl/fir_coeff_loader.sv | 129 ++++++++++++
 tb/tb_fir_coeff_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared FIR types and sizing helpers: loader FSM states, tap count, index width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } loader_state_t;

  // Number of taps for a FIR with the given number of delay blocks.
  function automatic int taps(input int delays);
    return delays + 1;
  endfunction

  // Width of an index that addresses n_taps entries; never narrower than 1 bit.
  function automatic int idx_width(input int n_taps);
    return (n_taps <= 2) ? 1 : $clog2(n_taps);
  endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Coefficient word stream: valid/ready handshake carrying one N-bit word plus an end-of-set flag.
// Latency: n/a (bundle of wires).
// Backpressure: the slave holds off the master by dropping load_ready; the master holds its word until taken.
//   load_valid : word and last flag are valid this cycle
//   load_ready : slave can take a word this cycle
//   load_data  : coefficient word, sent tap 0 first
//   load_last  : final word of a set
interface fir_coeff_loader_if #(
  parameter int N = 32
);
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] load_data;
  logic         load_last;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/fir_coeff_bank.sv
// Shadow coefficient bank plus the active bank driven to the FIR; commit copies shadow to active in one edge.
// Latency: a write lands in shadow on the next edge; b follows shadow one edge after commit.
// Backpressure: none; always accepts a write and a commit.
//   clk, rst : clock and async active-high reset (clears shadow and b)
//   wr_en/wr_idx/wr_dat : write one word into shadow[wr_idx]
//   commit   : copy the whole shadow into b
//   b        : active coefficients, tap i at bits [(i+1)*N-1 : i*N]
module fir_coeff_bank #(
  parameter int TAPS = 4,
  parameter int N    = 32,
  parameter int IW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [N-1:0]    wr_dat,
  input  logic            commit,
  output logic [TAPS*N-1:0] b
);

  logic [N-1:0]      shadow [TAPS];
  logic [TAPS*N-1:0] shadow_flat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) shadow[i] <= '0;
    end else if (wr_en) begin
      shadow[wr_idx] <= wr_dat;
    end
  end

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < TAPS; i++) shadow_flat[i*N +: N] = shadow[i];
  end

  // The active bank is only ever replaced as a whole, so the FIR never sees a mix of sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b <= '0;
    end else if (commit) begin
      b <= shadow_flat;
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Collects a serial set of TAPS coefficient words and swaps them into the FIR bus atomically on apply_en.
// Latency: with apply_en high, b updates one edge after the last word is taken; updated/err are 1-cycle registered pulses.
// Backpressure: load_ready low during reset release cycle and while a complete set waits for apply_en; no buffering.
//   clk, rst   : clock and async active-high reset
//   load       : coefficient stream (slave side)
//   apply_en   : commit permitted this cycle
//   abort      : flush a partial or pending set; wins over transfer and commit
//   b          : active coefficients, tap 0 in the LSBs
//   busy       : load in progress or commit pending
//   updated    : b changed this cycle
//   err        : malformed set discarded
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int DELAYS = 3,
  parameter int N      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  fir_coeff_loader_if.slave         load,
  input  logic                      apply_en,
  input  logic                      abort,
  output logic [taps(DELAYS)*N-1:0] b,
  output logic                      busy,
  output logic                      updated,
  output logic                      err
);

  localparam int            TAPS     = taps(DELAYS);
  localparam int            IW       = idx_width(TAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

  loader_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          rdy_en_q;
  logic          updated_q, err_q;
  logic          xfer, commit, err_d;

  // Held low through reset and the first edge after it, so ready rises one cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en_q <= 1'b0;
    else     rdy_en_q <= 1'b1;
  end

  assign load.load_ready = rdy_en_q && (state_q != PEND);
  assign busy            = (state_q != IDLE);
  assign updated         = updated_q;
  assign err             = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      updated_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      updated_q <= commit;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    // abort drops any word offered in the same cycle, even in IDLE.
    xfer    = load.load_valid && load.load_ready && !abort;

    case (state_q)
      IDLE, LOAD: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (xfer) begin
          if (idx_q == LAST_IDX) begin
            if (load.load_last) begin
              state_d = PEND;
            end else begin
              // Set longer than TAPS words.
              err_d   = 1'b1;
              state_d = IDLE;
              idx_d   = '0;
            end
          end else if (load.load_last) begin
            // Set shorter than TAPS words.
            err_d   = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            state_d = LOAD;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      PEND: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (apply_en) begin
          commit  = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  fir_coeff_bank #(
    .TAPS (TAPS),
    .N    (N),
    .IW   (IW)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (xfer),
    .wr_idx (idx_q),
    .wr_dat (load.load_data),
    .commit (commit),
    .b      (b)
  );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader (DELAYS=3, N=32): commit latency, backpressure, errors, abort, reset.
// Latency: n/a (testbench).
// Backpressure: source holds each word until load_ready is seen.
module tb_fir_coeff_loader;

  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          apply_en = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] b;
  logic          busy, updated, err;

  int checks   = 0;
  int failures = 0;

  fir_coeff_loader_if #(.N(32)) lif ();

  fir_coeff_loader #(.DELAYS(3), .N(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (lif),
    .apply_en (apply_en),
    .abort    (abort),
    .b        (b),
    .busy     (busy),
    .updated  (updated),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and return at posedge+1 after it was taken.
  task automatic send(input logic [31:0] d, input logic last, input int gap);
    bit taken;
    repeat (gap) tick();
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    lif.load_last  = last;
    taken = 0;
    for (int i = 0; i < 20 && !taken; i++) begin
      if (lif.load_ready) taken = 1;
      tick();
    end
    if (!taken) chk("send_ready_timeout", 0, 1);
    lif.load_valid = 1'b0;
    lif.load_last  = 1'b0;
  endtask

  task automatic wait_update(input string tag, input logic [BW-1:0] exp);
    bit seen;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (updated) seen = 1;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    else chk(tag, b, exp);
  endtask

  logic [BW-1:0] set1, set2, set3, set4, exp_set;
  logic [31:0]   w;

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_last  = 1'b0;
    set1 = {32'd4, 32'd3, 32'd2, 32'd1};
    set2 = {32'h40, 32'h30, 32'h20, 32'h10};
    set3 = {32'd8, 32'd7, 32'd6, 32'd5};
    set4 = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};

    // Reset state
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_b", b, '0);
    chk("rst_busy", BW'(busy), 0);
    chk("rst_ready", BW'(lif.load_ready), 0);
    chk("rst_updated", BW'(updated), 0);
    chk("rst_err", BW'(err), 0);
    rst = 1'b0;
    chk("rel_ready_low", BW'(lif.load_ready), 0);
    tick();
    chk("rel_ready_high", BW'(lif.load_ready), 1);

    // Basic load with apply_en held: commit exactly one edge after the last transfer
    apply_en = 1'b1;
    send(32'd1, 1'b0, 0);
    send(32'd2, 1'b0, 0);
    send(32'd3, 1'b0, 0);
    send(32'd4, 1'b1, 0);
    chk("t1_pend_busy", BW'(busy), 1);
    chk("t1_pend_ready", BW'(lif.load_ready), 0);
    chk("t1_pend_b_old", b, '0);
    chk("t1_pend_upd", BW'(updated), 0);
    tick();
    chk("t1_b", b, set1);
    chk("t1_upd", BW'(updated), 1);
    chk("t1_busy", BW'(busy), 0);
    chk("t1_ready", BW'(lif.load_ready), 1);
    tick();
    chk("t1_upd_pulse", BW'(updated), 0);
    chk("t1_b_hold", b, set1);

    // Commit held off by apply_en
    apply_en = 1'b0;
    send(32'h10, 1'b0, 0);
    send(32'h20, 1'b0, 0);
    send(32'h30, 1'b0, 0);
    send(32'h40, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_wait_ready", BW'(lif.load_ready), 0);
      chk("t2_wait_busy", BW'(busy), 1);
      chk("t2_wait_b", b, set1);
      tick();
    end
    apply_en = 1'b1;
    tick();
    chk("t2_b", b, set2);
    chk("t2_upd", BW'(updated), 1);

    // Short set: last on the 2nd word
    send(32'hA, 1'b0, 0);
    send(32'hB, 1'b1, 0);
    chk("t3_err", BW'(err), 1);
    chk("t3_busy", BW'(busy), 0);
    chk("t3_b", b, set2);
    tick();
    chk("t3_err_pulse", BW'(err), 0);
    send(32'd5, 1'b0, 0);
    send(32'd6, 1'b0, 0);
    send(32'd7, 1'b0, 0);
    send(32'd8, 1'b1, 0);
    tick();
    chk("t3_b_next", b, set3);
    chk("t3_upd_next", BW'(updated), 1);

    // Long set: 4th word without last
    send(32'hC1, 1'b0, 0);
    send(32'hC2, 1'b0, 0);
    send(32'hC3, 1'b0, 0);
    send(32'hC4, 1'b0, 0);
    chk("t4_err", BW'(err), 1);
    chk("t4_busy", BW'(busy), 0);
    chk("t4_b", b, set3);
    tick();

    // Abort together with the 3rd transfer
    send(32'h11, 1'b0, 0);
    send(32'h22, 1'b0, 0);
    lif.load_valid = 1'b1;
    lif.load_data  = 32'h33;
    abort = 1'b1;
    tick();
    lif.load_valid = 1'b0;
    abort = 1'b0;
    chk("ab_err", BW'(err), 0);
    chk("ab_busy", BW'(busy), 0);
    chk("ab_b", b, set3);

    // Abort in IDLE blocks a transfer
    lif.load_valid = 1'b1;
    lif.load_data  = 32'h44;
    abort = 1'b1;
    tick();
    lif.load_valid = 1'b0;
    abort = 1'b0;
    chk("ab_idle_busy", BW'(busy), 0);

    // Abort wins over a commit in PEND
    apply_en = 1'b0;
    send(32'h51, 1'b0, 0);
    send(32'h52, 1'b0, 0);
    send(32'h53, 1'b0, 0);
    send(32'h54, 1'b1, 0);
    chk("ab_pend_busy", BW'(busy), 1);
    abort = 1'b1;
    apply_en = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_pend_b", b, set3);
    chk("ab_pend_upd", BW'(updated), 0);
    chk("ab_pend_idle", BW'(busy), 0);

    // Async reset mid-LOAD
    send(32'h61, 1'b0, 0);
    send(32'h62, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rl_b", b, '0);
    chk("rl_busy", BW'(busy), 0);
    chk("rl_ready", BW'(lif.load_ready), 0);
    tick();
    rst = 1'b0;
    chk("rl_rel_ready", BW'(lif.load_ready), 0);
    tick();
    chk("rl_ready_up", BW'(lif.load_ready), 1);

    // Async reset in PEND, after a fresh commit so b is non-zero
    for (int i = 0; i < 4; i++) send(set4[i*32 +: 32], 1'(i == 3), 0);
    wait_update("rp_pre_b", set4);
    apply_en = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h70 + 32'(i), 1'(i == 3), 0);
    chk("rp_busy_pend", BW'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("rp_b", b, '0);
    chk("rp_busy", BW'(busy), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rp_ready_up", BW'(lif.load_ready), 1);

    // Back-to-back sets with random gaps; scoreboard is the word order sent
    apply_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 4; i++) begin
        w = $urandom;
        exp_set[i*32 +: 32] = w;
        send(w, 1'(i == 3), int'($urandom_range(0, 2)));
      end
      wait_update("rnd_b", exp_set);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
